// File: rtl/maze_pkg.sv
// Shared types for the wall-follower maze walker: headings, turn helpers and FSM states.
// Pure definitions, no timing or flow control of its own.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_S = 2'd1,
        DIR_W = 2'd2,
        DIR_N = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MARK  = 3'd1,
        ST_PROBE = 3'd2,
        ST_EVAL  = 3'd3,
        ST_MOVE  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    function automatic dir_t turn_right(input dir_t d);
        return dir_t'(d + 2'd1);
    endfunction

    function automatic dir_t turn_left(input dir_t d);
        return dir_t'(d + 2'd3);
    endfunction

    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d + 2'd2);
    endfunction

endpackage

// File: rtl/maze_dir_sel.sv
// Picks the k-th candidate heading for the chosen hand rule and its neighbour cell.
// Purely combinational; nb_valid is low when the step would leave the grid.
module maze_dir_sel
    import maze_pkg::*;
#(
    parameter int MAZE_W = 6
) (
    input  dir_t              heading,
    input  logic              hand,
    input  logic [1:0]        k,
    input  logic [MAZE_W-1:0] row,
    input  logic [MAZE_W-1:0] col,
    output dir_t              cand_dir,
    output logic [MAZE_W-1:0] nb_row,
    output logic [MAZE_W-1:0] nb_col,
    output logic              nb_valid
);

    localparam logic [MAZE_W-1:0] LAST = '1;

    always_comb begin
        case (k)
            2'd0:    cand_dir = hand ? turn_left(heading) : turn_right(heading);
            2'd1:    cand_dir = heading;
            2'd2:    cand_dir = hand ? turn_right(heading) : turn_left(heading);
            default: cand_dir = reverse(heading);
        endcase
    end

    always_comb begin
        nb_row   = row;
        nb_col   = col;
        nb_valid = 1'b1;
        case (cand_dir)
            DIR_E: begin
                nb_col   = col + MAZE_W'(1);
                nb_valid = (col != LAST);
            end
            DIR_S: begin
                nb_row   = row + MAZE_W'(1);
                nb_valid = (row != LAST);
            end
            DIR_W: begin
                nb_col   = col - MAZE_W'(1);
                nb_valid = (col != '0);
            end
            default: begin
                nb_row   = row - MAZE_W'(1);
                nb_valid = (row != '0);
            end
        endcase
    end

endmodule

// File: rtl/maze_walker.sv
// Wall-follower maze solver over an external 1-bit cell memory; probe = 2 cycles, move = 1 cycle.
// start is ignored while busy; the memory must answer a read strobe on the following cycle.
module maze_walker
    import maze_pkg::*;
#(
    parameter int MAZE_W    = 6,
    parameter int STEP_W    = 12,
    parameter int MAX_STEPS = 4095,
    parameter int START_DIR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hand_sel,
    input  logic [MAZE_W-1:0] starting_row,
    input  logic [MAZE_W-1:0] starting_col,
    input  logic              maze_in,
    output logic [MAZE_W-1:0] row,
    output logic [MAZE_W-1:0] col,
    output logic              maze_oe,
    output logic              maze_we,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [MAZE_W-1:0] LAST       = '1;
    localparam logic [STEP_W-1:0] MAX_CNT    = STEP_W'(MAX_STEPS);
    localparam dir_t              START_HEAD = dir_t'(2'(START_DIR));

    state_t              state_q, state_d;
    logic [MAZE_W-1:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [MAZE_W-1:0]   st_row_q, st_row_d, st_col_q, st_col_d;
    logic [MAZE_W-1:0]   nb_row_q, nb_row_d, nb_col_q, nb_col_d;
    logic [MAZE_W-1:0]   row_q, row_d, col_q, col_d;
    dir_t                head_q, head_d, cand_q, cand_d;
    logic                hand_q, hand_d;
    logic [1:0]          k_q, k_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                oe_q, oe_d, we_q, we_d;
    logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;

    logic [1:0]          sel_k;
    dir_t                sel_dir;
    logic [MAZE_W-1:0]   sel_row, sel_col;
    logic                sel_valid;
    logic                issue, go_fail, at_border, at_start;

    // The neighbour is looked up one cycle ahead so the strobe lands in PROBE and data in EVAL.
    always_comb begin
        sel_k = 2'd0;
        if (state_q == ST_PROBE || state_q == ST_EVAL) begin
            sel_k = k_q + 2'd1;
        end
    end

    maze_dir_sel #(
        .MAZE_W(MAZE_W)
    ) u_dir_sel (
        .heading (head_q),
        .hand    (hand_q),
        .k       (sel_k),
        .row     (cur_row_q),
        .col     (cur_col_q),
        .cand_dir(sel_dir),
        .nb_row  (sel_row),
        .nb_col  (sel_col),
        .nb_valid(sel_valid)
    );

    assign at_border = (cur_row_q == '0) || (cur_row_q == LAST) ||
                       (cur_col_q == '0) || (cur_col_q == LAST);
    assign at_start  = (cur_row_q == st_row_q) && (cur_col_q == st_col_q);

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        st_row_d  = st_row_q;
        st_col_d  = st_col_q;
        nb_row_d  = nb_row_q;
        nb_col_d  = nb_col_q;
        row_d     = row_q;
        col_d     = col_q;
        head_d    = head_q;
        cand_d    = cand_q;
        hand_d    = hand_q;
        k_d       = k_q;
        step_d    = step_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        oe_d      = 1'b0;
        we_d      = 1'b0;
        issue     = 1'b0;
        go_fail   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    st_row_d  = starting_row;
                    st_col_d  = starting_col;
                    cur_row_d = starting_row;
                    cur_col_d = starting_col;
                    row_d     = starting_row;
                    col_d     = starting_col;
                    hand_d    = hand_sel;
                    head_d    = START_HEAD;
                    k_d       = 2'd0;
                    step_d    = '0;
                    done_d    = 1'b0;
                    fail_d    = 1'b0;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    state_d   = ST_MARK;
                end
            end
            ST_MARK: issue = 1'b1;
            ST_PROBE: begin
                // oe_q low here means attempt k_q was off-grid and got skipped
                if (oe_q) begin
                    state_d = ST_EVAL;
                    row_d   = cur_row_q;
                    col_d   = cur_col_q;
                end else if (k_q == 2'd3) begin
                    go_fail = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_EVAL: begin
                if (!maze_in) begin
                    state_d   = ST_MOVE;
                    cur_row_d = nb_row_q;
                    cur_col_d = nb_col_q;
                    row_d     = nb_row_q;
                    col_d     = nb_col_q;
                    head_d    = cand_q;
                    step_d    = (step_q == MAX_CNT) ? step_q : step_q + STEP_W'(1);
                    we_d      = 1'b1;
                end else if (k_q == 2'd3) begin
                    go_fail = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            ST_MOVE: begin
                if (at_border && !at_start) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (step_q == MAX_CNT) begin
                    go_fail = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            state_d  = ST_PROBE;
            k_d      = sel_k;
            cand_d   = sel_dir;
            nb_row_d = sel_row;
            nb_col_d = sel_col;
            oe_d     = sel_valid;
            row_d    = sel_valid ? sel_row : cur_row_q;
            col_d    = sel_valid ? sel_col : cur_col_q;
        end

        if (go_fail) begin
            state_d = ST_FAIL;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
            row_d   = cur_row_q;
            col_d   = cur_col_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            st_row_q  <= '0;
            st_col_q  <= '0;
            nb_row_q  <= '0;
            nb_col_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            head_q    <= DIR_E;
            cand_q    <= DIR_E;
            hand_q    <= 1'b0;
            k_q       <= 2'd0;
            step_q    <= '0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            st_row_q  <= st_row_d;
            st_col_q  <= st_col_d;
            nb_row_q  <= nb_row_d;
            nb_col_q  <= nb_col_d;
            row_q     <= row_d;
            col_q     <= col_d;
            head_q    <= head_d;
            cand_q    <= cand_d;
            hand_q    <= hand_d;
            k_q       <= k_d;
            step_q    <= step_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign row        = row_q;
    assign col        = col_q;
    assign maze_oe    = oe_q;
    assign maze_we    = we_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker on an 8x8 maze: directed scenarios plus random mazes checked against
// a high-level wall-follower reference model. Instance b uses a 5-move limit.
module tb_maze_walker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, hand_sel;
    logic [2:0] srow, scol;
    logic       a_in, b_in;
    logic [2:0] a_row, a_col, b_row, b_col;
    logic       a_oe, a_we, a_busy, a_done, a_fail;
    logic       b_oe, b_we, b_busy, b_done, b_fail;
    logic [11:0] a_step, b_step;

    maze_walker #(.MAZE_W(3), .STEP_W(12), .MAX_STEPS(100), .START_DIR(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .hand_sel(hand_sel),
        .starting_row(srow), .starting_col(scol), .maze_in(a_in),
        .row(a_row), .col(a_col), .maze_oe(a_oe), .maze_we(a_we),
        .busy(a_busy), .done(a_done), .fail(a_fail), .step_count(a_step)
    );

    maze_walker #(.MAZE_W(3), .STEP_W(12), .MAX_STEPS(5), .START_DIR(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .hand_sel(hand_sel),
        .starting_row(srow), .starting_col(scol), .maze_in(b_in),
        .row(b_row), .col(b_col), .maze_oe(b_oe), .maze_we(b_we),
        .busy(b_busy), .done(b_done), .fail(b_fail), .step_count(b_step)
    );

    // Cell memory shared by both walkers; only one walks at a time, so one log serves both.
    logic       mz [64];
    int         reads_total = 0;
    int         clash_total = 0;
    logic [5:0] wlog [$];

    always @(posedge clk) begin
        if (a_oe) a_in <= mz[{a_row, a_col}];
        if (b_oe) b_in <= mz[{b_row, b_col}];
        if (a_oe || b_oe) reads_total++;
        if (a_we) wlog.push_back({a_row, a_col});
        if (b_we) wlog.push_back({b_row, b_col});
        if ((a_oe && a_we) || (b_oe && b_we)) clash_total++;
    end

    logic        use_b;
    logic        s_busy, s_done, s_fail;
    logic [2:0]  s_row, s_col;
    logic [11:0] s_step;
    assign s_busy = use_b ? b_busy : a_busy;
    assign s_done = use_b ? b_done : a_done;
    assign s_fail = use_b ? b_fail : a_fail;
    assign s_row  = use_b ? b_row  : a_row;
    assign s_col  = use_b ? b_col  : a_col;
    assign s_step = use_b ? b_step : a_step;

    int checks = 0;
    int errors = 0;
    int read_base, wlog_base;

    int exp_done, exp_fail, exp_r, exp_c, exp_steps, exp_reads;
    int exp_w [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic walls_all();
        for (int i = 0; i < 64; i++) mz[i] = 1'b1;
    endtask

    task automatic free(input int r, input int c);
        mz[r * 8 + c] = 1'b0;
    endtask

    // Reference: walk the maze cell by cell with the hand rule, counting in-grid probes.
    task automatic model_walk(input int sr, input int sc, input bit hand, input int maxs);
        int offr [4] = '{1, 0, 3, 2};
        int offl [4] = '{3, 0, 1, 2};
        int dr   [4] = '{0, 1, 0, -1};
        int dc   [4] = '{1, 0, -1, 0};
        int r, c, h, d, nr, nc;
        bit moved;
        r = sr; c = sc; h = 0;
        exp_steps = 0; exp_reads = 0; exp_done = 0; exp_fail = 0;
        exp_w.delete();
        exp_w.push_back(r * 8 + c);
        while (exp_done == 0 && exp_fail == 0) begin
            moved = 0;
            for (int k = 0; k < 4 && !moved; k++) begin
                d  = (h + (hand ? offl[k] : offr[k])) % 4;
                nr = r + dr[d];
                nc = c + dc[d];
                if (nr >= 0 && nr < 8 && nc >= 0 && nc < 8) begin
                    exp_reads++;
                    if (!mz[nr * 8 + nc]) begin
                        r = nr; c = nc; h = d; moved = 1;
                        exp_steps++;
                        exp_w.push_back(r * 8 + c);
                    end
                end
            end
            if (!moved) exp_fail = 1;
            else if ((r == 0 || r == 7 || c == 0 || c == 7) && !(r == sr && c == sc)) exp_done = 1;
            else if (exp_steps == maxs) exp_fail = 1;
        end
        exp_r = r;
        exp_c = c;
    endtask

    task automatic run(input bit on_b, input int sr, input int sc, input bit hand, input string tag);
        int n;
        use_b     = on_b;
        read_base = reads_total;
        wlog_base = wlog.size();
        srow      = 3'(sr);
        scol      = 3'(sc);
        hand_sel  = hand;
        if (on_b) start_b = 1'b1;
        else      start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        n = 0;
        while (s_busy && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_finished"}, 32'(s_busy), 32'd0);
    endtask

    task automatic check_model(input string tag);
        int nw;
        nw = wlog.size() - wlog_base;
        chk({tag, "_done"},   32'(s_done), 32'(exp_done));
        chk({tag, "_fail"},   32'(s_fail), 32'(exp_fail));
        chk({tag, "_row"},    32'(s_row),  32'(exp_r));
        chk({tag, "_col"},    32'(s_col),  32'(exp_c));
        chk({tag, "_steps"},  32'(s_step), 32'(exp_steps));
        chk({tag, "_reads"},  32'(reads_total - read_base), 32'(exp_reads));
        chk({tag, "_nwrite"}, 32'(nw), 32'(exp_w.size()));
        for (int i = 0; i < nw && i < exp_w.size(); i++)
            chk({tag, "_waddr"}, 32'(wlog[wlog_base + i]), 32'(exp_w[i]));
    endtask

    initial begin
        int n, sr, sc;
        bit hand;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; hand_sel = 1'b0;
        srow = '0; scol = '0; use_b = 1'b0;
        walls_all();
        tick();
        tick();
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_fail", 32'(a_fail), 0);
        chk("rst_oe",   32'(a_oe | b_oe), 0);
        chk("rst_we",   32'(a_we | b_we), 0);
        chk("rst_rc",   32'({a_row, a_col, b_row, b_col}), 0);
        chk("rst_step", 32'(a_step | b_step), 0);
        rst = 1'b0;
        tick();

        // Straight corridor along row 3
        walls_all();
        for (int c = 3; c < 8; c++) free(3, c);
        model_walk(3, 3, 0, 100);
        run(0, 3, 3, 0, "corr");
        chk("corr_done", 32'(a_done), 1);
        chk("corr_rc",   32'({a_row, a_col}), 32'({3'd3, 3'd7}));
        chk("corr_step", 32'(a_step), 4);
        check_model("corr");

        // T-junction: right rule goes south, left rule goes north
        walls_all();
        for (int c = 3; c < 6; c++) free(3, c);
        for (int r = 0; r < 8; r++) free(r, 5);
        model_walk(3, 3, 0, 100);
        run(0, 3, 3, 0, "tee_r");
        chk("tee_r_rc", 32'({a_row, a_col}), 32'({3'd7, 3'd5}));
        check_model("tee_r");
        model_walk(3, 3, 1, 100);
        run(0, 3, 3, 1, "tee_l");
        chk("tee_l_rc", 32'({a_row, a_col}), 32'({3'd0, 3'd5}));
        check_model("tee_l");

        // Enclosed start cell
        walls_all();
        free(3, 3);
        model_walk(3, 3, 0, 100);
        run(0, 3, 3, 0, "encl");
        chk("encl_fail",  32'(a_fail), 1);
        chk("encl_step",  32'(a_step), 0);
        chk("encl_reads", 32'(reads_total - read_base), 4);
        chk("encl_nw",    32'(wlog.size() - wlog_base), 1);

        // Timeout on a 2x2 loop with the 5-move walker
        walls_all();
        free(3, 3); free(3, 4); free(4, 3); free(4, 4);
        model_walk(3, 3, 0, 5);
        run(1, 3, 3, 0, "loop");
        chk("loop_fail", 32'(b_fail), 1);
        chk("loop_done", 32'(b_done), 0);
        chk("loop_step", 32'(b_step), 5);
        check_model("loop");

        // Border start with left rule: the north probe must be skipped, not wrapped
        walls_all();
        for (int r = 0; r < 8; r++) free(r, 4);
        model_walk(0, 4, 1, 100);
        run(0, 0, 4, 1, "bord");
        chk("bord_done", 32'(a_done), 1);
        chk("bord_rc",   32'({a_row, a_col}), 32'({3'd7, 3'd4}));
        chk("bord_step", 32'(a_step), 7);
        check_model("bord");

        // Reset while a read result is being evaluated
        walls_all();
        for (int c = 3; c < 8; c++) free(3, c);
        use_b    = 1'b0;
        srow     = 3'd3;
        scol     = 3'd3;
        hand_sel = 1'b0;
        start_a  = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!a_oe && n < 50) begin
            tick();
            n++;
        end
        chk("rstmid_saw_oe", 32'(a_oe), 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_busy", 32'(a_busy), 0);
        chk("rstmid_oewe", 32'({a_oe, a_we}), 0);
        chk("rstmid_rc",   32'({a_row, a_col}), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("rstmid_idle_oewe", 32'({a_oe, a_we}), 0);
        model_walk(3, 3, 0, 100);
        run(0, 3, 3, 0, "rerun");
        check_model("rerun");

        // Random mazes against the reference walk
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 64; i++) mz[i] = ($urandom_range(0, 99) < 35);
            sr   = $urandom_range(0, 7);
            sc   = $urandom_range(0, 7);
            hand = 1'($urandom_range(0, 1));
            free(sr, sc);
            model_walk(sr, sc, hand, 100);
            run(0, sr, sc, hand, "rand");
            check_model("rand");
        end

        chk("oe_we_clash", 32'(clash_total), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
